// File: rtl/rr_leading_one_arbiter.sv
// Round-robin arbiter, leading-one (highest index) wins on a rotating mask.
// Optional watchdog release when LOA_TIMEOUT_EN is defined.
module rr_leading_one_arbiter #(
  parameter int N_REQ          = 9,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [IDX_W-1:0] NONE = '1;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             load;
  logic             expire;
  logic             release_w;
  logic [N_REQ-1:0] cand;

  function automatic logic [IDX_W-1:0] lead_one(
    input logic [N_REQ-1:0] v
  );
    lead_one = NONE;
    for (int i = 0; i < N_REQ; i++)
      if (v[i]) lead_one = IDX_W'(i);
  endfunction

  function automatic logic [IDX_W-1:0] pick(
    input logic [N_REQ-1:0] r,
    input logic [N_REQ-1:0] m
  );
    logic [N_REQ-1:0] mr;
    mr = r & m;
    pick = (mr != '0) ? lead_one(mr) : lead_one(r);
  endfunction

  // Bits strictly below k; k=0 reopens the full range.
  function automatic logic [N_REQ-1:0] below(
    input logic [IDX_W-1:0] k
  );
    below = '1;
    if (k != '0)
      for (int i = 0; i < N_REQ; i++)
        below[i] = (IDX_W'(i) < k);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IDX_W-1:0] k
  );
    onehot = '0;
    for (int i = 0; i < N_REQ; i++)
      onehot[i] = (IDX_W'(i) == k);
  endfunction

  assign cand      = req_i & ~grant_q;
  assign release_w = (state_q == GRANT) && (done_i || expire);

`ifdef LOA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expire = (state_q == GRANT) && !done_i &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (state_d == GRANT && !load)
      cnt_q <= cnt_q + 1'b1;
    else
      cnt_q <= '0;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    tmo_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          idx_d   = pick(req_i, mask_q);
          grant_d = onehot(idx_d);
          state_d = GRANT;
          load    = 1'b1;
        end
      end
      GRANT: begin
        if (release_w) begin
          mask_d = below(idx_q);
          tmo_d  = expire;
          if (cand != '0) begin
            idx_d   = pick(cand, mask_d);
            grant_d = onehot(idx_d);
            load    = 1'b1;
          end else begin
            idx_d   = NONE;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == GRANT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '1;
      grant_q <= '0;
      idx_q   <= NONE;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_idx_o   = idx_q;
  assign timeout_o     = tmo_q;

endmodule
